spi_mode_sequencer: RTL and testbench

Test scheduler that drives `spi_master` through the four SPI modes, (CPOL,CPHA) = 00, 01, 10, 11, one 64-byte run per enabled mode. For each mode it:
- holds the master in reset with the mode pins stable;
- releases reset and enables transmit and/or receive;
- waits for `spi_over`;
- samples `receive_status`, then records pass/fail and timeout per mode.

It sits between the board-level test control and `spi_master`, and owns the master's reset, enable and mode pins.

---
 rtl/spi_mode_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_spi_mode_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mode_sequencer.sv
// rtl/spi_mode_sequencer.sv - sweeps spi_master through SPI modes 0..3 and records pass/timeout per mode
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, abort        sweep control from board-level test logic
//   mode_mask[3:0]      bit m enables mode m (m[1]=CPOL, m[0]=CPHA), latched at start
//   dir_sel[1:0]        [1]=tx enable, [0]=rx enable, latched at start
//   spi_over            master finished its 64-byte run
//   receive_status      master's data-match result, one clock after spi_over
//   spi_rst_n           registered reset to the master
//   spi_tx_en/rx_en     master enables
//   mode_select_CPOL/CPHA  master mode pins
//   busy, done          sweep in progress / one-cycle end-of-sweep pulse
//   pass_mask, timeout_mask  per-mode results
module spi_mode_sequencer #(
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 4095,
  parameter int TO_W          = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] mode_mask,
  input  logic [1:0] dir_sel,
  input  logic       spi_over,
  input  logic       receive_status,
  output logic       spi_rst_n,
  output logic       spi_tx_en,
  output logic       spi_rx_en,
  output logic       mode_select_CPOL,
  output logic       mode_select_CPHA,
  output logic       busy,
  output logic       done,
  output logic [3:0] pass_mask,
  output logic [3:0] timeout_mask
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_RESET, S_SETTLE, S_RUN, S_CHECK, S_NEXT, S_DONE
  } state_t;

  localparam logic [TO_W-1:0] RST_LAST    = TO_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] SETTLE_LAST = TO_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] CHECK_LAST  = TO_W'(1);

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_d;
  logic [3:0]      mask_q, mask_d;
  logic [1:0]      dir_q, dir_d;
  logic [TO_W-1:0] cnt;

  logic       spi_rst_n_d, tx_en_d, rx_en_d, cpol_d, cpha_d, busy_d, done_d;
  logic [3:0] pass_d, to_d;

  logic aborting;
  assign aborting = abort && (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (aborting) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Nothing to run: skip straight to the end-of-sweep pulse.
            if (mode_mask == 4'd0 || dir_sel == 2'd0) state_nxt = S_DONE;
            else                                      state_nxt = S_SELECT;
          end
        end
        S_SELECT: begin
          if (mask_q[idx])       state_nxt = S_RESET;
          else if (idx == 2'd3)  state_nxt = S_DONE;
        end
        S_RESET:  if (cnt == RST_LAST)    state_nxt = S_SETTLE;
        S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_RUN;
        S_RUN: begin
          if (spi_over)            state_nxt = S_CHECK;
          else if (cnt == TO_LAST) state_nxt = S_NEXT;
        end
        S_CHECK:  if (cnt == CHECK_LAST)  state_nxt = S_NEXT;
        S_NEXT:   state_nxt = (idx == 2'd3) ? S_DONE : S_SELECT;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values. Outputs are registered from the current
  // state, so each pin follows its state by one clock; abort is the exception
  // and clears the master pins on the abort edge itself.
  always_comb begin
    spi_rst_n_d = 1'b0;
    tx_en_d     = 1'b0;
    rx_en_d     = 1'b0;
    cpol_d      = mode_select_CPOL;
    cpha_d      = mode_select_CPHA;
    busy_d      = (state != S_IDLE);
    done_d      = (state == S_DONE);
    pass_d      = pass_mask;
    to_d        = timeout_mask;
    idx_d       = idx;
    mask_d      = mask_q;
    dir_d       = dir_q;
    if (aborting) begin
      busy_d = 1'b0;
      done_d = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_d = mode_mask;
            dir_d  = dir_sel;
            pass_d = 4'd0;
            to_d   = 4'd0;
            idx_d  = 2'd0;
          end
        end
        S_SELECT: begin
          // Mode pins only move here, while the master is held in reset.
          if (mask_q[idx]) begin
            cpol_d = idx[1];
            cpha_d = idx[0];
          end else if (idx != 2'd3) begin
            idx_d = idx + 2'd1;
          end
        end
        S_SETTLE: spi_rst_n_d = 1'b1;
        S_RUN: begin
          spi_rst_n_d = 1'b1;
          tx_en_d     = dir_q[1];
          rx_en_d     = dir_q[0];
          if (!spi_over && cnt == TO_LAST) to_d[idx] = 1'b1;
        end
        S_CHECK: begin
          spi_rst_n_d = 1'b1;
          tx_en_d     = dir_q[1];
          rx_en_d     = dir_q[0];
          // receive_status lags spi_over by a clock, so sample on the second cycle.
          // A tx-only run has no receive data to judge, so completion is a pass.
          if (cnt == CHECK_LAST) pass_d[idx] = dir_q[0] ? receive_status : 1'b1;
        end
        S_NEXT: begin
          if (idx != 2'd3) idx_d = idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_rst_n        <= 1'b0;
      spi_tx_en        <= 1'b0;
      spi_rx_en        <= 1'b0;
      mode_select_CPOL <= 1'b0;
      mode_select_CPHA <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_mask        <= 4'd0;
      timeout_mask     <= 4'd0;
      idx              <= 2'd0;
      mask_q           <= 4'd0;
      dir_q            <= 2'd0;
    end else begin
      spi_rst_n        <= spi_rst_n_d;
      spi_tx_en        <= tx_en_d;
      spi_rx_en        <= rx_en_d;
      mode_select_CPOL <= cpol_d;
      mode_select_CPHA <= cpha_d;
      busy             <= busy_d;
      done             <= done_d;
      pass_mask        <= pass_d;
      timeout_mask     <= to_d;
      idx              <= idx_d;
      mask_q           <= mask_d;
      dir_q            <= dir_d;
    end
  end

  // Per-state cycle counter: restarts at 0 on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state || state == S_IDLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_spi_mode_sequencer.sv
// tb/tb_spi_mode_sequencer.sv - self-checking bench for spi_mode_sequencer
module tb_spi_mode_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int SETTLE_CYCLES = 2;
  localparam int TIMEOUT       = 4095;
  localparam int TO_W          = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] mode_mask = 4'd0;
  logic [1:0] dir_sel = 2'd0;
  logic       spi_over = 1'b0;
  logic       receive_status = 1'b0;
  logic       spi_rst_n, spi_tx_en, spi_rx_en;
  logic       mode_select_CPOL, mode_select_CPHA;
  logic       busy, done;
  logic [3:0] pass_mask, timeout_mask;

  always #5 clk = ~clk;

  spi_mode_sequencer #(
    .RST_CYCLES(RST_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mode_mask(mode_mask), .dir_sel(dir_sel),
    .spi_over(spi_over), .receive_status(receive_status),
    .spi_rst_n(spi_rst_n), .spi_tx_en(spi_tx_en), .spi_rx_en(spi_rx_en),
    .mode_select_CPOL(mode_select_CPOL), .mode_select_CPHA(mode_select_CPHA),
    .busy(busy), .done(done), .pass_mask(pass_mask), .timeout_mask(timeout_mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Master model: spi_over after over_delay enabled cycles (0 = never),
  // receive_status one clock later, low for modes flagged in rs_fail.
  bit         model_en = 1'b0;
  int         over_delay = 0;
  logic [3:0] rs_fail = 4'd0;
  int         run_cnt = 0;
  bit         fired = 1'b0;

  initial begin : master_model
    logic [1:0] md;
    forever begin
      @(posedge clk);
      #1;
      if (model_en) begin
        md = {mode_select_CPOL, mode_select_CPHA};
        if (!spi_rst_n) begin
          run_cnt = 0; fired = 1'b0; spi_over = 1'b0; receive_status = 1'b0;
        end else begin
          if (spi_over) begin
            spi_over = 1'b0;
            receive_status = ~rs_fail[md];
          end
          if ((spi_tx_en || spi_rx_en) && !fired) begin
            run_cnt++;
            if (over_delay != 0 && run_cnt == over_delay) begin
              spi_over = 1'b1;
              fired = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor
  int         runs = 0, done_cnt = 0, viol = 0, en_cycles = 0;
  logic [7:0] seq = 8'd0;
  bit         rx_seen = 1'b0;
  logic       prev_en = 1'b0, prev_rst = 1'b0;
  logic [1:0] prev_mode = 2'd0;

  initial begin : monitor
    logic en;
    forever begin
      @(negedge clk);
      en = spi_tx_en | spi_rx_en;
      if (en && !prev_en) begin
        seq = {seq[5:0], mode_select_CPOL, mode_select_CPHA};
        runs++;
      end
      if (en) en_cycles++;
      if (spi_rx_en) rx_seen = 1'b1;
      if (en && !spi_rst_n) viol++;
      if (spi_rst_n && prev_rst && {mode_select_CPOL, mode_select_CPHA} != prev_mode) viol++;
      if (done) done_cnt++;
      prev_en   = en;
      prev_rst  = spi_rst_n;
      prev_mode = {mode_select_CPOL, mode_select_CPHA};
    end
  end

  task automatic clear_mon();
    runs = 0; done_cnt = 0; viol = 0; en_cycles = 0; seq = 8'd0; rx_seen = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] m, input logic [1:0] d);
    @(negedge clk);
    mode_mask = m; dir_sel = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit got);
    got = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_mode_run(input logic [1:0] md, input int bound, output bit got);
    got = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (spi_tx_en && {mode_select_CPOL, mode_select_CPHA} == md) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] dir;
    int         delay;
    logic [3:0] fail;
    logic [3:0] exp_pass;
    logic [3:0] exp_to;
    logic [7:0] exp_seq;
    int         exp_runs;
    bit         exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit got;
    int k_rst, k_en;

    vecs[0] = '{4'hF, 2'b11, 1216, 4'h0, 4'hF, 4'h0, 8'h1B, 4, 1'b1};
    vecs[1] = '{4'h5, 2'b10, 1216, 4'hF, 4'h5, 4'h0, 8'h02, 2, 1'b0};
    vecs[2] = '{4'h8, 2'b11, 0,    4'h0, 4'h0, 4'h8, 8'h03, 1, 1'b1};
    vecs[3] = '{4'hF, 2'b11, 1216, 4'h4, 4'hB, 4'h0, 8'h1B, 4, 1'b1};
    vecs[4] = '{4'h2, 2'b01, 100,  4'h0, 4'h2, 4'h0, 8'h01, 1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_spi_rst_n", spi_rst_n, 0);
    chk("rst_tx_en", spi_tx_en, 0);
    chk("rst_rx_en", spi_rx_en, 0);
    chk("rst_mode", {mode_select_CPOL, mode_select_CPHA}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_masks", {pass_mask, timeout_mask}, 0);
    rst_n = 1'b1;

    // Latencies from start, and spi_over -> pass -> enable drop timing
    model_en = 1'b0;
    clear_mon();
    do_start(4'b0001, 2'b11);
    chk("busy_at_start_edge", busy, 0);
    k_rst = -1; k_en = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_after_start", busy, 1);
      if (spi_rst_n && k_rst < 0) k_rst = k;
      if (spi_tx_en && k_en < 0) k_en = k;
    end
    chk("rst_release_lat", k_rst, RST_CYCLES + 2);
    chk("en_assert_lat", k_en, RST_CYCLES + SETTLE_CYCLES + 2);
    spi_over = 1'b1;
    @(negedge clk);
    spi_over = 1'b0; receive_status = 1'b1;
    chk("pass_at_K", pass_mask, 4'h0);
    @(negedge clk);
    chk("pass_at_K1", pass_mask, 4'h0);
    @(negedge clk);
    chk("pass_at_K2", pass_mask, 4'h1);
    chk("en_at_K2", spi_tx_en, 1);
    @(negedge clk);
    chk("en_at_K3", {spi_tx_en, spi_rx_en}, 0);
    chk("rst_at_K3", spi_rst_n, 0);
    repeat (3) @(negedge clk);
    chk("done_at_K6", done, 0);
    @(negedge clk);
    chk("done_at_K7", done, 1);
    @(negedge clk);
    chk("busy_at_K8", busy, 0);
    receive_status = 1'b0;

    // Abort in mode 1 RUN
    model_en = 1'b1; over_delay = 1216; rs_fail = 4'h0;
    clear_mon();
    do_start(4'hF, 2'b11);
    wait_mode_run(2'b01, 4000, got);
    chk("abort_reach_mode1", got, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_spi_rst_n", spi_rst_n, 0);
    chk("abort_en", {spi_tx_en, spi_rx_en}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pass_kept", pass_mask, 4'h1);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);

    // start while busy is ignored
    over_delay = 50;
    clear_mon();
    do_start(4'h1, 2'b11);
    repeat (20) @(negedge clk);
    do_start(4'hF, 2'b11);
    wait_done(2000, got);
    chk("busy_start_done", got, 1);
    repeat (3) @(negedge clk);
    chk("busy_start_runs", runs, 1);
    chk("busy_start_pass", pass_mask, 4'h1);

    // Empty mask: done two clocks after start, no runs
    clear_mon();
    @(negedge clk);
    mode_mask = 4'h0; dir_sel = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done_N", done, 0);
    @(negedge clk);
    chk("empty_done_N1", done, 1);
    @(negedge clk);
    chk("empty_busy_N2", {busy, done}, 0);
    // Empty direction behaves the same
    do_start(4'hF, 2'b00);
    repeat (4) @(negedge clk);
    chk("empty_runs", runs, 0);
    chk("empty_done_cnt", done_cnt, 2);

    // Asynchronous reset in mode 1 RUN
    over_delay = 1216;
    clear_mon();
    do_start(4'h3, 2'b11);
    wait_mode_run(2'b01, 4000, got);
    chk("areset_reach_mode1", got, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_spi_rst_n", spi_rst_n, 0);
    chk("areset_en", {spi_tx_en, spi_rx_en}, 0);
    chk("areset_mode", {mode_select_CPOL, mode_select_CPHA}, 0);
    chk("areset_busy_done", {busy, done}, 0);
    chk("areset_masks", {pass_mask, timeout_mask}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven full sweeps
    for (int i = 0; i < 5; i++) begin
      model_en = 1'b1; over_delay = vecs[i].delay; rs_fail = vecs[i].fail;
      clear_mon();
      do_start(vecs[i].mask, vecs[i].dir);
      wait_done(20000, got);
      chk($sformatf("v%0d_done_seen", i), got, 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_pass", i), pass_mask, vecs[i].exp_pass);
      chk($sformatf("v%0d_timeout", i), timeout_mask, vecs[i].exp_to);
      chk($sformatf("v%0d_seq", i), seq, vecs[i].exp_seq);
      chk($sformatf("v%0d_runs", i), runs, vecs[i].exp_runs);
      chk($sformatf("v%0d_rx_seen", i), rx_seen, vecs[i].exp_rx);
      chk($sformatf("v%0d_pin_viol", i), viol, 0);
      chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      if (vecs[i].delay == 0)
        chk($sformatf("v%0d_to_run_len", i),
            (en_cycles >= TIMEOUT && en_cycles <= TIMEOUT + 1), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
